// File: rtl/spi_tx_if.sv
// Word handshake between the transmit FIFO and the SPI transmit engine.
`timescale 1ns/1ps
interface spi_tx_if #(
    parameter int unsigned FIFO_WIDTH = 32
);
    logic [FIFO_WIDTH-1:0] tx_wdata_i;
    logic                  tx_vld_i;
    logic                  tx_rdy_o;

    modport master (
        output tx_wdata_i,
        output tx_vld_i,
        input  tx_rdy_o
    );

    modport slave (
        input  tx_wdata_i,
        input  tx_vld_i,
        output tx_rdy_o
    );
endinterface

// File: rtl/spi_tx.sv
// SPI master transmit engine: one word per chip-select frame, MSB first, all
// four CPOL/CPHA modes, paced by half-period strobes from an external clock gen.
`timescale 1ns/1ps
module spi_tx #(
    parameter int unsigned FIFO_WIDTH = 32
) (
    input  logic    clk_i,
    input  logic    rst_n_i,
    input  logic    cpol,
    input  logic    cpoa,
    spi_tx_if.slave tx,
    input  logic    bit_en,
    output logic    clk_gen,
    output logic    sclk,
    output logic    cs_n,
    output logic    sdo
);

    localparam int unsigned W     = FIFO_WIDTH;
    localparam int unsigned EDGES = 2 * W;
    localparam int unsigned CW    = $clog2(EDGES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t         state;
    logic [W-1:0]   shreg;
    logic           mode_cpol;
    logic           mode_cpoa;
    logic [CW-1:0]  edge_cnt;
    logic           tx_rdy_q;

    logic [CW-1:0]  edge_nxt;
    logic           accept;
    logic           last_edge;
    logic           launch_edge;

    assign tx.tx_rdy_o = tx_rdy_q;
    assign accept      = tx.tx_vld_i & tx_rdy_q;
    assign edge_nxt    = edge_cnt + CW'(1);
    assign last_edge   = (edge_nxt == CW'(EDGES));

    // Data launch edges: odd edges when sampling on the second edge, even
    // edges (except the final one) when sampling on the first edge.
    assign launch_edge = mode_cpoa ? edge_nxt[0] : (~edge_nxt[0] & ~last_edge);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            shreg     <= '0;
            mode_cpol <= 1'b0;
            mode_cpoa <= 1'b0;
            edge_cnt  <= '0;
            tx_rdy_q  <= 1'b1;
            clk_gen   <= 1'b0;
            cs_n      <= 1'b1;
            sdo       <= 1'b0;
            sclk      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sclk <= cpol;
                    if (accept) begin
                        shreg     <= tx.tx_wdata_i;
                        mode_cpol <= cpol;
                        mode_cpoa <= cpoa;
                        edge_cnt  <= '0;
                        tx_rdy_q  <= 1'b0;
                        clk_gen   <= 1'b1;
                        cs_n      <= 1'b0;
                        // First-edge sampling needs the MSB on the wire before any sclk edge.
                        sdo       <= cpoa ? 1'b0 : tx.tx_wdata_i[W-1];
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    if (bit_en) begin
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (bit_en) begin
                        edge_cnt <= edge_nxt;
                        sclk     <= ~sclk;
                        if (launch_edge) begin
                            sdo   <= mode_cpoa ? shreg[W-1] : shreg[W-2];
                            shreg <= {shreg[W-2:0], 1'b0};
                        end
                        if (last_edge) begin
                            state <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (bit_en) begin
                        cs_n     <= 1'b1;
                        sdo      <= 1'b0;
                        clk_gen  <= 1'b0;
                        tx_rdy_q <= 1'b1;
                        edge_cnt <= '0;
                        sclk     <= mode_cpol;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
